imem_stream_loader: RTL and testbench

- Writer side of the instruction-memory interface: the pipelined CPU fetches from instruction memory, and this block fills that memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes each instruction to consecutive word addresses.
- Holds the CPU in reset until the load completes. Sits between the testbench/host byte source and the instruction-memory write port, beside cpu_pipeline.

---
 rtl/imem_stream_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_stream_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream loader that fills instruction memory and holds the CPU until done
// Optional checksum byte after the payload: define IMEM_LOADER_CHECKSUM_EN.
module imem_stream_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // Where the stream goes once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [23:0]       buf_q, buf_d;
  logic [15:0]       wc_q, wc_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [16:0] len_next;
  logic        last_word;

  assign accept    = in_valid && in_ready_q;
  assign len_next  = {1'b0, in_data, wc_q[7:0]};
  assign last_word = (17'(ptr_q) == (17'(wc_q) - 17'd1));

  // Next-state, byte assembly and registered output values.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept && (state_q == S_LEN0 || state_q == S_LEN1 || state_q == S_DATA)) begin
      csum_d = csum_q ^ in_data;
    end
`endif
    case (state_q)
      S_LEN0: begin
        if (accept) begin
          wc_d[7:0] = in_data;
          state_d   = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          wc_d[15:8] = in_data;
          if (len_next == 17'd0) begin
            state_d = S_AFTER_DATA;
          end else if (len_next > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          case (lane_q)
            2'd0: buf_d[7:0]   = in_data;
            2'd1: buf_d[15:8]  = in_data;
            2'd2: buf_d[23:16] = in_data;
            default: begin
              wdata_d = {in_data, buf_q};
              addr_d  = ptr_q;
              we_d    = 1'b1;
              ptr_d   = ptr_q + 1'b1;
              if (last_word) begin
                state_d = S_AFTER_DATA;
              end
            end
          endcase
          lane_d = lane_q + 2'd1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = ((csum_q ^ in_data) == 8'h00) ? S_DONE : S_ERR;
        end
      end
`endif
      default: ;
    endcase
    in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    hold_d = !done_d;
  end

  // State and output registers; reset restarts the load and drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN0;
      lane_q     <= 2'd0;
      ptr_q      <= '0;
      buf_q      <= 24'd0;
      wc_q       <= 16'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      wc_q       <= wc_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - directed self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int base;

  imem_stream_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) we_count <= we_count + 1;
  end

  task automatic apply_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_byte_timeout got in_ready=%0b want 1 (byte %02h)", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got %0b want 0", imem_we); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got %0b want 1", cpu_hold); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %0b%0b want 00", done, err); end
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL rst_word_count got %h want 0", word_count); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %0b want 1", in_ready); end
  endtask

  // Sends the two data words of the nominal stream and checks each write strobe.
  task automatic send_nominal_data();
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL early_we got %0b want 0", imem_we); end
    send_byte(8'h00);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h00A00513) begin
      errors++; $display("FAIL word0 got we=%0b addr=%h data=%h want 1 00 00a00513", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h00B00593) begin
      errors++; $display("FAIL word1 got we=%0b addr=%h data=%h want 1 01 00b00593", imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic check_nominal_end(input int b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h92);
`endif
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL nom_done got done=%0b hold=%0b want 1 0", done, cpu_hold);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_low got %0b want 0", in_ready); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL nom_word_count got %0d want 2", word_count); end
    @(negedge clk);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL nom_we_single got %0b want 0", imem_we); end
    checks++; if (we_count - b0 !== 2) begin errors++; $display("FAIL nom_we_count got %0d want 2", we_count - b0); end
  endtask

  task automatic test_nominal();
    apply_reset();
    base = we_count;
    send_byte(8'h02); send_byte(8'h00);
    send_nominal_data();
    check_nominal_end(base);
  endtask

  task automatic test_zero_length();
    apply_reset();
    base = we_count;
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%0b hold=%0b err=%0b want 1 0 0", done, cpu_hold, err);
    end
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready got %0b want 0", in_ready); end
    checks++; if (we_count !== base) begin errors++; $display("FAIL zero_no_we got %0d want 0", we_count - base); end
  endtask

  task automatic test_oversize();
    apply_reset();
    base = we_count;
    send_byte(8'h01); send_byte(8'h01);
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL over_err got err=%0b hold=%0b done=%0b want 1 1 0", err, cpu_hold, done);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_ready got %0b want 0", in_ready); end
    checks++; if (we_count !== base) begin errors++; $display("FAIL over_no_we got %0d want 0", we_count - base); end
    checks++; if (word_count !== 16'h0101) begin errors++; $display("FAIL over_word_count got %h want 0101", word_count); end
    // Exactly DEPTH words is legal and must proceed to data.
    apply_reset();
    send_byte(8'h00); send_byte(8'h01);
    checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL depth_ok got err=%0b ready=%0b want 0 1", err, in_ready);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    base = we_count;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL stall_we cycle %0d got %0b want 0", i, imem_we); end
    end
    send_byte(8'h05); send_byte(8'hA0);
    send_byte(8'h00);
    checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h00A00513) begin
      errors++; $display("FAIL stall_word0 got we=%0b data=%h want 1 00a00513", imem_we, imem_wdata);
    end
    send_byte(8'h93); send_byte(8'h05); send_byte(8'hB0); send_byte(8'h00);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h00B00593) begin
      errors++; $display("FAIL stall_word1 got we=%0b addr=%h data=%h want 1 01 00b00593", imem_we, imem_addr, imem_wdata);
    end
    check_nominal_end(base);
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    base = we_count;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0);
    // Sixth byte coincides with reset, so the word never completes.
    in_valid = 1'b1; in_data = 8'h00; reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    checks++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || word_count !== 16'h0) begin
      errors++; $display("FAIL mid_rst got we=%0b ready=%0b wc=%h want 0 0 0", imem_we, in_ready, word_count);
    end
    @(negedge clk);
    checks++; if (we_count !== base) begin errors++; $display("FAIL mid_rst_no_we got %0d want 0", we_count - base); end
    send_byte(8'h02); send_byte(8'h00);
    send_nominal_data();
    check_nominal_end(base);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    apply_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_nominal_data();
    send_byte(8'h93);
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL csum_bad got err=%0b hold=%0b done=%0b want 1 1 0", err, cpu_hold, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_zero_length();
    test_oversize();
    test_stall();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
